det_tridiag_n: RTL

- Parametrised successor to the fixed-size tridiagonal determinant engine.
- Reads an order-`size` tridiagonal matrix (runtime, up to N_MAX) from dual-port SRAM and evaluates f_i = a_i*f_{i-1} - b_{i-1}*c_{i-1}*f_{i-2}, with f_{-1}=1 and f_{-2}=0.
- Writes det = f_{size-1} back to SRAM, flags true signed overflow, and pulses `finished`.
- Sits beside the SRAM as a bus master and is started by the top-level sequencer via `go`.

---
 rtl/det_tridiag_n.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/det_tridiag_n.sv
// det_tridiag_n: tridiagonal determinant engine acting as an SRAM bus master.
// Optional macro DET_TRACE_EN also writes each partial f_i to TRACE_BASE+i.
module det_tridiag_n #(
  parameter int N_MAX      = 16,
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 32,
  parameter int ADDR_W     = 7,
  parameter int RD_BASE    = 0,
  parameter int WR_ADDR    = 14,
  parameter int TRACE_BASE = 48
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          go,
  input  logic [$clog2(N_MAX+1)-1:0]    size,
  input  logic [2*DATA_W-1:0]           readbus,
  output logic [ADDR_W-1:0]             readAddress,
  output logic [ADDR_W-1:0]             writeAddress,
  output logic [ACC_W-1:0]              writebus,
  output logic                          WE,
  output logic                          overflow,
  output logic                          finished
);

  localparam int SIZE_W = $clog2(N_MAX+1);
  localparam int F_W    = ACC_W + 2*DATA_W + 1;

  if (RD_BASE + 2*N_MAX > (1 << ADDR_W) || WR_ADDR >= (1 << ADDR_W) ||
      TRACE_BASE + N_MAX > (1 << ADDR_W)) begin : g_cfg_check
    $error("det_tridiag_n: address map does not fit in ADDR_W");
  end

  typedef enum logic [1:0] {IDLE, FETCH, CALC, WRITE} state_t;

  state_t                     state_q, state_d;
  logic [SIZE_W-1:0]          n_q, n_d, i_q, i_d, n_in;
  logic signed [DATA_W-1:0]   a_q, a_d;
  logic signed [2*DATA_W-1:0] bc_q, bc_d;
  logic signed [ACC_W-1:0]    f1_q, f1_d, f2_q, f2_d;
  logic [ADDR_W-1:0]          ra_d, wa_d;
  logic [ACC_W-1:0]           wb_d;
  logic                       we_d, ovf_d, fin_d;

  logic signed [F_W-1:0]      a_x, f1_x, bc_x, f2_x, f_full;
  logic signed [2*DATA_W-1:0] b_x, c_x;
  logic [F_W-ACC_W:0]         f_top;
  logic                       f_ovf, last_row;

  // Recurrence evaluated exactly at F_W bits; overflow means the bits above
  // the ACC_W sign bit are not a pure sign extension.
  always_comb begin
    a_x      = {{(F_W-DATA_W){a_q[DATA_W-1]}}, a_q};
    f1_x     = {{(F_W-ACC_W){f1_q[ACC_W-1]}}, f1_q};
    f2_x     = {{(F_W-ACC_W){f2_q[ACC_W-1]}}, f2_q};
    bc_x     = {{(F_W-2*DATA_W){bc_q[2*DATA_W-1]}}, bc_q};
    f_full   = a_x * f1_x - bc_x * f2_x;
    f_top    = f_full[F_W-1:ACC_W-1];
    f_ovf    = !((&f_top) || !(|f_top));
    b_x      = {{DATA_W{readbus[2*DATA_W-1]}}, readbus[2*DATA_W-1:DATA_W]};
    c_x      = {{DATA_W{readbus[DATA_W-1]}}, readbus[DATA_W-1:0]};
    last_row = (i_q == n_q - SIZE_W'(1));
    n_in     = (size > SIZE_W'(N_MAX)) ? SIZE_W'(N_MAX) : size;
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    a_d     = a_q;
    bc_d    = bc_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    ra_d    = readAddress;
    wa_d    = writeAddress;
    wb_d    = writebus;
    we_d    = WE;
    ovf_d   = overflow;
    fin_d   = finished;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          n_d   = n_in;
          f1_d  = ACC_W'(1);
          f2_d  = '0;
          bc_d  = '0;
          i_d   = '0;
          ovf_d = 1'b0;
          fin_d = 1'b0;
          ra_d  = ADDR_W'(RD_BASE);
          if (n_in == '0) begin
            wb_d    = ACC_W'(1);
            wa_d    = ADDR_W'(WR_ADDR);
            we_d    = 1'b1;
            state_d = WRITE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        a_d     = readbus[DATA_W-1:0];
        ra_d    = readAddress + ADDR_W'(1);
`ifdef DET_TRACE_EN
        we_d    = 1'b0;
`endif
        state_d = CALC;
      end
      CALC: begin
        if (f_ovf) ovf_d = 1'b1;
        f2_d = f1_q;
        f1_d = f_full[ACC_W-1:0];
        bc_d = b_x * c_x;
        if (last_row) begin
          wb_d    = f_full[ACC_W-1:0];
          wa_d    = ADDR_W'(WR_ADDR);
          we_d    = 1'b1;
          state_d = WRITE;
        end else begin
          i_d     = i_q + SIZE_W'(1);
          ra_d    = readAddress + ADDR_W'(1);
`ifdef DET_TRACE_EN
          we_d    = 1'b1;
          wa_d    = ADDR_W'(TRACE_BASE) + ADDR_W'(i_q);
          wb_d    = f_full[ACC_W-1:0];
`endif
          state_d = FETCH;
        end
      end
      WRITE: begin
        we_d    = 1'b0;
        fin_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      i_q          <= '0;
      a_q          <= '0;
      bc_q         <= '0;
      f1_q         <= ACC_W'(1);
      f2_q         <= '0;
      readAddress  <= ADDR_W'(RD_BASE);
      writeAddress <= ADDR_W'(WR_ADDR);
      writebus     <= '0;
      WE           <= 1'b0;
      overflow     <= 1'b0;
      finished     <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      i_q          <= i_d;
      a_q          <= a_d;
      bc_q         <= bc_d;
      f1_q         <= f1_d;
      f2_q         <= f2_d;
      readAddress  <= ra_d;
      writeAddress <= wa_d;
      writebus     <= wb_d;
      WE           <= we_d;
      overflow     <= ovf_d;
      finished     <= fin_d;
    end
  end

endmodule
